// File: rtl/tft_timing_ctrl.sv
// tft_timing_ctrl: horizontal/vertical timing generator and pixel output stage
// for an RGB TFT panel. The free-running h/v counters drive the pixel request
// and the active-area coordinates combinationally. The upstream pixel source
// answers a request in the same cycle. Sync, data-enable and RGB565 pixel are
// then registered, so they all leave this block with the same one-cycle latency.
module tft_timing_ctrl #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [23:0] DATA,
    output logic        Data_Req,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLK,
    output logic [15:0] VGA_RGB,
    output logic        Frame_Start
);

    // Sums must fit in 11 bits; that constraint is left to the integrator.
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_MAX     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
    localparam logic [10:0] H_START_L = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] V_START_L = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] H_END_L   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_END_L   = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;

    logic        w_h_active;
    logic        w_v_active;
    logic        w_first_pix;
    logic [15:0] w_rgb565;

    // Free-running line/frame counters; the vertical counter steps only on line wrap.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
        end else if (r_h_cnt == H_MAX) begin
            r_h_cnt <= 11'd0;
            r_v_cnt <= (r_v_cnt == V_MAX) ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    // Active-window decode, pixel request and zero-clamped active-area coordinates.
    always_comb begin
        w_h_active  = (r_h_cnt >= H_START_L) && (r_h_cnt < H_END_L);
        w_v_active  = (r_v_cnt >= V_START_L) && (r_v_cnt < V_END_L);
        Data_Req    = w_h_active && w_v_active;
        hcount      = Data_Req ? (r_h_cnt - H_START_L) : 11'd0;
        vcount      = Data_Req ? (r_v_cnt - V_START_L) : 11'd0;
        w_first_pix = Data_Req && (hcount == 11'd0) && (vcount == 11'd0);
        // Plain truncation to RGB565; DATA only matters while a pixel is requested.
        w_rgb565    = Data_Req ? {DATA[23:19], DATA[15:10], DATA[7:3]} : 16'h0000;
    end

    // Panel-facing outputs, all registered from the same counter state.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            VGA_BLK     <= 1'b0;
            VGA_RGB     <= 16'h0000;
            Frame_Start <= 1'b0;
        end else begin
            VGA_HS      <= (r_h_cnt < H_SYNC_L) ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= (r_v_cnt < V_SYNC_L) ? SYNC_POL : ~SYNC_POL;
            VGA_BLK     <= Data_Req;
            VGA_RGB     <= w_rgb565;
            Frame_Start <= w_first_pix;
        end
    end

endmodule
